// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, legal data-width range and
// the parity helper used by the transmit (and later receive) paths.
package uart_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Caller zero-extends narrower words; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake of the UART transmitter: the bus pushes words, the
// transmitter reports whether its FIFO can take one.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
) ();

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with occupancy count, shared by the UART transmit and
// receive paths. Pushes into a full FIFO and pops from an empty one are ignored.
module uart_fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count
  // decide which entries are valid, and an unreset RAM maps onto memory cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words serialized LSB-first with
// optional even/odd parity and one or two stop bits, paced by baud_tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          baud_tick,
  uart_tx_cfg_if.slave                  bus,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int CNT_W = $clog2(DATA_W_MAX + 1);

  uart_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              stop_ext_q, stop_ext_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              start_frame;

  uart_fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (bus.tx_valid),
    .wdata (bus.tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.tx_ready = !fifo_full;
  assign txd          = txd_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    txd_d       = txd_q;
    par_en_d    = par_en_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    stop_ext_d  = stop_ext_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) start_frame = 1'b1;
        end
        START: begin
          txd_d     = shift_q[0];
          bit_cnt_d = CNT_W'(1);
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q < CNT_W'(DATA_W)) begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (par_en_q) begin
            txd_d   = par_q;
            state_d = PARITY;
          end else begin
            txd_d      = 1'b1;
            stop_ext_d = 1'b0;
            state_d    = STOP;
          end
        end
        PARITY: begin
          txd_d      = 1'b1;
          stop_ext_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          // The first of two stop bits only extends the line-high period.
          if (stop2_q && !stop_ext_q) begin
            stop_ext_d = 1'b1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    // Frame start: pop the word, latch this frame's configuration and its parity.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      txd_d    = 1'b0;
      state_d  = START;
      par_en_d = parity_en;
      stop2_d  = stop2;
      par_d    = parity_bit(DATA_W_MAX'(fifo_rdata), parity_odd);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_ext_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_ext_q <= stop_ext_d;
    end
  end

endmodule
